fetch_unit: RTL and testbench

- Upstream neighbour of the RV32I instruction memory. Owns the program counter (PC) and drives the word-aligned fetch address into the memory.
- Takes the combinational instruction word back from the memory and presents instr, pc and pc+4 to decode/execute.
- Sequences boot, run, halt-on-EBREAK and fatal fetch traps, and keeps a retired-instruction counter.

---
 rtl/rv32_pkg.sv | 27 ++
 rtl/pc_next_sel.sv | 57 +++++
 rtl/fetch_unit.sv | 127 ++++++++++++
 tb/tb_fetch_unit.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_pkg.sv
// Shared RV32 definitions for the fetch front end: fetch FSM states,
// well-known instruction encodings and the address range helper.
package rv32_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] INSTR_NOP    = 32'h0000_0013;
    localparam logic [XLEN-1:0] INSTR_EBREAK = 32'h0010_0073;

    typedef enum logic [1:0] {
        FETCH_BOOT = 2'd0,
        FETCH_RUN  = 2'd1,
        FETCH_HALT = 2'd2,
        FETCH_TRAP = 2'd3
    } fetch_state_t;

    // An address is out of range when any bit at or above addr_w is set.
    // A memory as wide as the address space has no out-of-range addresses.
    function automatic logic addr_out_of_range(input logic [XLEN-1:0] addr,
                                               input int unsigned     addr_w);
        if (addr_w >= XLEN) begin
            return 1'b0;
        end
        return (addr >> addr_w) != '0;
    endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC priority selection and fetch trap detection for one RUN cycle.
// Purely combinational; the caller only acts on these results in RUN.
module pc_next_sel
    import rv32_pkg::*;
#(
    parameter int unsigned IMEM_ADDR_W = 12
) (
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] pc_plus4,
    input  logic [XLEN-1:0] instr,
    input  logic            stall,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_target,
    output logic            pc_load,
    output logic [XLEN-1:0] pc_next,
    output logic            retire,
    output logic            go_halt,
    output logic            go_trap,
    output logic [XLEN-1:0] trap_addr
);

    // Priority chain: stall, EBREAK, misaligned target, out-of-range target,
    // taken redirect, out-of-range fall-through, sequential fetch.
    always_comb begin
        pc_load   = 1'b0;
        pc_next   = pc;
        retire    = 1'b0;
        go_halt   = 1'b0;
        go_trap   = 1'b0;
        trap_addr = '0;
        if (stall) begin
            // Redirect is dropped here; upstream re-presents it.
        end else if (instr == INSTR_EBREAK) begin
            go_halt = 1'b1;
        end else if (redirect && (redirect_target[1:0] != 2'b00)) begin
            go_trap   = 1'b1;
            trap_addr = redirect_target;
        end else if (redirect && addr_out_of_range(redirect_target, IMEM_ADDR_W)) begin
            go_trap   = 1'b1;
            trap_addr = redirect_target;
        end else if (redirect) begin
            pc_load = 1'b1;
            pc_next = redirect_target;
            retire  = 1'b1;
        end else if (addr_out_of_range(pc_plus4, IMEM_ADDR_W)) begin
            // The instruction at pc itself was fine, so it still retires.
            go_trap   = 1'b1;
            trap_addr = pc_plus4;
            retire    = 1'b1;
        end else begin
            pc_load = 1'b1;
            pc_next = pc_plus4;
            retire  = 1'b1;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// RV32I fetch unit: owns the PC, presents instr/pc/pc+4 from a zero-latency
// instruction memory, and sequences boot, run, EBREAK halt and fetch traps.
module fetch_unit
    import rv32_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned IMEM_ADDR_W = 12,
    parameter int unsigned INSTRET_W   = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    output logic [XLEN-1:0]      imem_addr,
    input  logic [XLEN-1:0]      imem_instr,
    input  logic                 stall,
    input  logic                 redirect,
    input  logic [XLEN-1:0]      redirect_target,
    input  logic                 resume,
    output logic [XLEN-1:0]      instr,
    output logic                 instr_valid,
    output logic [XLEN-1:0]      pc,
    output logic [XLEN-1:0]      pc_plus4,
    output logic                 halted,
    output logic                 trap,
    output logic [XLEN-1:0]      trap_addr,
    output logic [INSTRET_W-1:0] instret
);

    fetch_state_t    state;
    fetch_state_t    state_next;
    logic            sel_pc_load;
    logic [XLEN-1:0] sel_pc_next;
    logic            sel_retire;
    logic            sel_go_halt;
    logic            sel_go_trap;
    logic [XLEN-1:0] sel_trap_addr;

    // Memory is addressed directly by the PC; pc + 4 wraps modulo 2^32.
    assign imem_addr = pc;
    assign pc_plus4  = pc + 32'd4;

    pc_next_sel #(
        .IMEM_ADDR_W(IMEM_ADDR_W)
    ) u_pc_next_sel (
        .pc             (pc),
        .pc_plus4       (pc_plus4),
        .instr          (imem_instr),
        .stall          (stall),
        .redirect       (redirect),
        .redirect_target(redirect_target),
        .pc_load        (sel_pc_load),
        .pc_next        (sel_pc_next),
        .retire         (sel_retire),
        .go_halt        (sel_go_halt),
        .go_trap        (sel_go_trap),
        .trap_addr      (sel_trap_addr)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FETCH_BOOT;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state: BOOT lasts one cycle, TRAP is left only by reset.
    always_comb begin
        state_next = state;
        case (state)
            FETCH_BOOT: state_next = FETCH_RUN;
            FETCH_RUN: begin
                if (sel_go_halt) begin
                    state_next = FETCH_HALT;
                end else if (sel_go_trap) begin
                    state_next = FETCH_TRAP;
                end
            end
            FETCH_HALT: begin
                if (resume) begin
                    state_next = FETCH_RUN;
                end
            end
            default: state_next = state;
        endcase
    end

    // FSM outputs: instruction is only exposed while running, NOP otherwise.
    always_comb begin
        instr_valid = (state == FETCH_RUN);
        halted      = (state == FETCH_HALT);
        trap        = (state == FETCH_TRAP);
        instr       = instr_valid ? imem_instr : INSTR_NOP;
    end

    // PC, retired-instruction counter and trap address registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc        <= RESET_PC;
            instret   <= '0;
            trap_addr <= '0;
        end else begin
            case (state)
                FETCH_RUN: begin
                    if (sel_pc_load) begin
                        pc <= sel_pc_next;
                    end
                    if (sel_retire) begin
                        instret <= instret + INSTRET_W'(1);
                    end
                    if (sel_go_trap) begin
                        trap_addr <= sel_trap_addr;
                    end
                end
                FETCH_HALT: begin
                    // Resume steps over the EBREAK.
                    if (resume) begin
                        pc <= pc_plus4;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: directed stimulus, a behavioural model of the
// fetch rules compared every cycle, plus hand-computed literal checks.
module tb_fetch_unit;

    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] EBRK   = 32'h0010_0073;
    localparam logic [31:0] ADDI   = 32'h0010_8093;
    localparam logic [31:0] IMEM_BYTES = 32'd4096;

    localparam int M_BOOT = 0;
    localparam int M_RUN  = 1;
    localparam int M_HALT = 2;
    localparam int M_TRAP = 3;

    logic        clk;
    logic        rst_n;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_target;
    logic        resume;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        halted;
    logic        trap;
    logic [31:0] trap_addr;
    logic [63:0] instret;

    logic [31:0] mem [0:1023];

    int errors = 0;
    int checks = 0;
    logic chk_en = 1'b0;

    // Model state
    int          m_mode    = M_BOOT;
    logic [31:0] m_pc      = 32'h0;
    logic [63:0] m_instret = 64'd0;
    logic [31:0] m_trap    = 32'h0;

    fetch_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .stall          (stall),
        .redirect       (redirect),
        .redirect_target(redirect_target),
        .resume         (resume),
        .instr          (instr),
        .instr_valid    (instr_valid),
        .pc             (pc),
        .pc_plus4       (pc_plus4),
        .halted         (halted),
        .trap           (trap),
        .trap_addr      (trap_addr),
        .instret        (instret)
    );

    assign imem_instr = mem[imem_addr[11:2]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic bad_target(input logic [31:0] t);
        return ((t % 32'd4) != 32'd0) || (t >= IMEM_BYTES);
    endfunction

    // Behavioural model of the fetch rules
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode    <= M_BOOT;
            m_pc      <= 32'h0;
            m_instret <= 64'd0;
            m_trap    <= 32'h0;
        end else begin
            case (m_mode)
                M_BOOT: m_mode <= M_RUN;
                M_RUN: begin
                    if (stall) begin
                    end else if (mem[m_pc[11:2]] == EBRK) begin
                        m_mode <= M_HALT;
                    end else if (redirect && bad_target(redirect_target)) begin
                        m_mode <= M_TRAP;
                        m_trap <= redirect_target;
                    end else if (redirect) begin
                        m_pc      <= redirect_target;
                        m_instret <= m_instret + 64'd1;
                    end else if ((m_pc + 32'd4) >= IMEM_BYTES || (m_pc + 32'd4) == 32'd0) begin
                        m_mode    <= M_TRAP;
                        m_trap    <= m_pc + 32'd4;
                        m_instret <= m_instret + 64'd1;
                    end else begin
                        m_pc      <= m_pc + 32'd4;
                        m_instret <= m_instret + 64'd1;
                    end
                end
                M_HALT: begin
                    if (resume) begin
                        m_pc   <= m_pc + 32'd4;
                        m_mode <= M_RUN;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_pc", 64'(pc), 64'(m_pc));
            check("cyc_imem_addr", 64'(imem_addr), 64'(m_pc));
            check("cyc_pc_plus4", 64'(pc_plus4), 64'(m_pc + 32'd4));
            check("cyc_instret", instret, m_instret);
            check("cyc_valid", 64'(instr_valid), 64'(m_mode == M_RUN));
            check("cyc_halted", 64'(halted), 64'(m_mode == M_HALT));
            check("cyc_trap", 64'(trap), 64'(m_mode == M_TRAP));
            check("cyc_trap_addr", 64'(trap_addr), 64'(m_trap));
            check("cyc_instr", 64'(instr),
                  64'((m_mode == M_RUN) ? mem[m_pc[11:2]] : NOP));
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = ADDI;
        mem[4] = EBRK;
        stall = 1'b0;
        redirect = 1'b0;
        redirect_target = 32'h0;
        resume = 1'b0;
        rst_n = 1'b0;
        tick();
        tick();
        chk_en = 1'b1;

        // Reset state
        check("rst_pc", 64'(pc), 64'h0);
        check("rst_instret", instret, 64'd0);
        check("rst_valid", 64'(instr_valid), 64'd0);
        check("rst_instr", 64'(instr), 64'(32'h0000_0013));
        check("rst_halted", 64'(halted), 64'd0);
        check("rst_trap", 64'(trap), 64'd0);

        // BOOT cycle, then sequential fetch
        rst_n = 1'b1;
        check("boot_valid", 64'(instr_valid), 64'd0);
        tick();
        check("run0_pc", 64'(pc), 64'h0);
        check("run0_valid", 64'(instr_valid), 64'd1);
        tick();
        check("run1_pc", 64'(pc), 64'h4);
        tick();
        check("run2_pc", 64'(pc), 64'h8);
        check("run2_instret", instret, 64'd2);

        // Stalled redirect is dropped, then taken
        stall = 1'b1; redirect = 1'b1; redirect_target = 32'h40;
        tick();
        check("stall_pc", 64'(pc), 64'h8);
        check("stall_instret", instret, 64'd2);
        stall = 1'b0;
        tick();
        check("redir_pc", 64'(pc), 64'h40);
        check("redir_instret", instret, 64'd3);

        // EBREAK at 0x10 halts without retiring
        redirect_target = 32'h10;
        tick();
        redirect = 1'b0;
        check("pre_ebrk_instret", instret, 64'd4);
        tick();
        check("halt_halted", 64'(halted), 64'd1);
        check("halt_pc", 64'(pc), 64'h10);
        check("halt_instret", instret, 64'd4);
        check("halt_instr", 64'(instr), 64'(32'h0000_0013));
        redirect = 1'b1; redirect_target = 32'h80;
        tick();
        redirect = 1'b0;
        check("halt_hold_pc", 64'(pc), 64'h10);
        resume = 1'b1;
        tick();
        check("resume_pc", 64'(pc), 64'h14);
        check("resume_halted", 64'(halted), 64'd0);
        tick();
        resume = 1'b0;
        check("resume_in_run_pc", 64'(pc), 64'h18);
        check("resume_in_run_instret", instret, 64'd5);

        // Sequential fetch off the end of memory
        redirect = 1'b1; redirect_target = 32'hFF8;
        tick();
        redirect = 1'b0;
        tick();
        check("edge_pc", 64'(pc), 64'hFFC);
        tick();
        check("edge_trap", 64'(trap), 64'd1);
        check("edge_trap_addr", 64'(trap_addr), 64'h1000);
        check("edge_pc_frozen", 64'(pc), 64'hFFC);
        check("edge_instret", instret, 64'd8);
        redirect = 1'b1; redirect_target = 32'h20; resume = 1'b1;
        tick();
        tick();
        redirect = 1'b0; resume = 1'b0;
        check("trap_sticky", 64'(trap), 64'd1);
        check("trap_sticky_pc", 64'(pc), 64'hFFC);

        // Out-of-range redirect target
        do_reset();
        tick();
        tick();
        redirect = 1'b1; redirect_target = 32'h2000;
        tick();
        redirect = 1'b0;
        check("oor_trap", 64'(trap), 64'd1);
        check("oor_trap_addr", 64'(trap_addr), 64'h2000);
        check("oor_pc", 64'(pc), 64'h4);
        check("oor_instret", instret, 64'd1);

        // Misaligned redirect target
        do_reset();
        tick();
        tick();
        tick();
        redirect = 1'b1; redirect_target = 32'h42;
        tick();
        check("mis_trap", 64'(trap), 64'd1);
        check("mis_trap_addr", 64'(trap_addr), 64'h42);
        check("mis_pc", 64'(pc), 64'h8);
        check("mis_instr", 64'(instr), 64'(32'h0000_0013));
        redirect_target = 32'h40; resume = 1'b1;
        tick();
        tick();
        redirect = 1'b0; resume = 1'b0;
        check("mis_pc_frozen", 64'(pc), 64'h8);
        check("mis_trap_addr_held", 64'(trap_addr), 64'h42);

        // Stall has priority over EBREAK
        do_reset();
        tick();
        redirect = 1'b1; redirect_target = 32'h10;
        tick();
        redirect = 1'b0; stall = 1'b1;
        tick();
        tick();
        check("stall_ebrk_halted", 64'(halted), 64'd0);
        check("stall_ebrk_pc", 64'(pc), 64'h10);
        stall = 1'b0;

        // Asynchronous reset between clock edges
        do_reset();
        tick();
        tick();
        tick();
        check("pre_async_pc", 64'(pc), 64'h8);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_pc", 64'(pc), 64'h0);
        check("async_instret", instret, 64'd0);
        check("async_valid", 64'(instr_valid), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
